// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared state encodings, register constants and the load-use
//            hazard helper for the RV32I pipeline control unit.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller state encodings; also exposed on the debug state port
    localparam logic [1:0] c_pc_run   = 2'd0;
    localparam logic [1:0] c_pc_flush = 2'd1;
    localparam logic [1:0] c_pc_hold  = 2'd2;

    // x0 is hard-wired to zero, so a load into it never creates a hazard
    localparam logic [4:0] c_zero_reg = 5'd0;

    // A load in ex whose destination is read by the instruction in id
    function automatic logic f_load_use(
        input logic       is_load,
        input logic [4:0] wd_addr,
        input logic [4:0] rs1_addr,
        input logic [4:0] rs2_addr
    );
        return is_load && (wd_addr != c_zero_reg) &&
               ((wd_addr == rs1_addr) || (wd_addr == rs2_addr));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_perf
// Brief    : Stall-cycle and redirect counters for the pipeline controller.
//            Instantiated only when PIPE_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_pc_i,
    input  logic        jump_en_i,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running wrap-around counters; every cycle with jump_en high is a
    // distinct redirect, so back-to-back redirects each count once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (hold_pc_i) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (jump_en_i) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline control for the RV32I core. Arbitrates execute-stage
//            redirects, bus hold requests and load-use hazards into PC hold,
//            if_id hold/flush and id_ex bubble controls. Outputs are
//            combinational from state and inputs (zero-cycle latency).
//            Optional macro PIPE_CTRL_PERF_EN adds stall/redirect counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_req_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        ex_is_load_i,
    input  logic [4:0]  ex_wd_addr_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic [1:0]  state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    // Flush cycles still owed after the redirect cycle itself
    localparam logic [2:0] c_fcnt_reload = 3'(FLUSH_CYCLES - 1);
    localparam logic       c_multi_flush = (FLUSH_CYCLES > 1);

    logic [1:0]  r_state;
    logic [2:0]  r_fcnt;
    logic        r_pend;
    logic [31:0] r_pend_addr;

    logic [1:0]  w_state_nxt;
    logic [2:0]  w_fcnt_nxt;
    logic        w_pend_nxt;
    logic [31:0] w_pend_addr_nxt;
    logic        w_redirect;
    logic [31:0] w_redirect_addr;
    logic        w_stall;
    logic        w_load_use;

    assign w_load_use = f_load_use(ex_is_load_i, ex_wd_addr_i, rs1_addr_i, rs2_addr_i);

    // Next-state and control decode; redirect and stall are resolved first,
    // then drive the outputs and the common redirect state update
    always_comb begin
        w_state_nxt     = r_state;
        w_fcnt_nxt      = r_fcnt;
        w_pend_nxt      = r_pend;
        w_pend_addr_nxt = r_pend_addr;
        w_redirect      = 1'b0;
        w_redirect_addr = '0;
        w_stall         = 1'b0;
        jump_en_o       = 1'b0;
        jump_addr_o     = '0;
        hold_pc_o       = 1'b0;
        hold_if_id_o    = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;

        if (!rst) begin
            case (r_state)
                c_pc_run: begin
                    if (jump_en_i) begin
                        w_redirect      = 1'b1;
                        w_redirect_addr = jump_addr_i;
                    end else if (hold_req_i) begin
                        w_stall     = 1'b1;
                        w_state_nxt = c_pc_hold;
                    end else if (w_load_use) begin
                        w_stall = 1'b1;
                    end
                end
                c_pc_flush: begin
                    // Instructions behind a redirect are dead: hold and
                    // load-use are irrelevant here
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (jump_en_i) begin
                        w_redirect      = 1'b1;
                        w_redirect_addr = jump_addr_i;
                    end else begin
                        w_fcnt_nxt = r_fcnt - 3'd1;
                        if (r_fcnt <= 3'd1) begin
                            w_fcnt_nxt  = '0;
                            w_state_nxt = c_pc_run;
                        end
                    end
                end
                c_pc_hold: begin
                    if (hold_req_i) begin
                        w_stall = 1'b1;
                        if (jump_en_i) begin
                            w_pend_nxt      = 1'b1;
                            w_pend_addr_nxt = jump_addr_i;
                        end
                    end else if (jump_en_i) begin
                        // A fresh redirect supersedes anything parked
                        w_redirect      = 1'b1;
                        w_redirect_addr = jump_addr_i;
                    end else if (r_pend) begin
                        w_redirect      = 1'b1;
                        w_redirect_addr = r_pend_addr;
                    end else begin
                        w_state_nxt = c_pc_run;
                        w_stall     = w_load_use;
                    end
                end
                default: begin
                    w_state_nxt = c_pc_run;
                end
            endcase

            if (w_redirect) begin
                jump_en_o     = 1'b1;
                jump_addr_o   = w_redirect_addr;
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                w_pend_nxt    = 1'b0;
                if (c_multi_flush) begin
                    w_state_nxt = c_pc_flush;
                    w_fcnt_nxt  = c_fcnt_reload;
                end else begin
                    w_state_nxt = c_pc_run;
                    w_fcnt_nxt  = '0;
                end
            end

            if (w_stall) begin
                hold_pc_o     = 1'b1;
                hold_if_id_o  = 1'b1;
                flush_id_ex_o = 1'b1;
            end
        end
    end

    // State register; reset drops any parked jump and remaining flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_pc_run;
            r_fcnt      <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    assign state_o = rst ? c_pc_run : r_state;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk              (clk),
        .rst              (rst),
        .hold_pc_i        (hold_pc_o),
        .jump_en_i        (jump_en_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl: directed scenarios followed
//            by random traffic, compared each cycle against a behavioural
//            model built from the redirect/hold/load-use rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_req;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ex_is_load;
    logic [4:0]  ex_wd;

    logic        jump_en_out;
    logic [31:0] jump_addr_out;
    logic        hold_pc;
    logic        hold_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model: flush cycles still owed, hold in progress, parked jump
    int          m_flush_left = 0;
    bit          m_holding    = 0;
    bit          m_pend_v     = 0;
    logic [31:0] m_pend_a     = '0;
    int          m_stall_cnt  = 0;
    int          m_jump_cnt   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en),
        .jump_addr_i   (jump_addr),
        .hold_req_i    (hold_req),
        .rs1_addr_i    (rs1),
        .rs2_addr_i    (rs2),
        .ex_is_load_i  (ex_is_load),
        .ex_wd_addr_i  (ex_wd),
        .jump_en_o     (jump_en_out),
        .jump_addr_o   (jump_addr_out),
        .hold_pc_o     (hold_pc),
        .hold_if_id_o  (hold_if_id),
        .flush_if_id_o (flush_if_id),
        .flush_id_ex_o (flush_id_ex),
        .state_o       (state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_flush_cnt_o (perf_flush_cnt)
`endif
    );

    task automatic idle();
        rst = 0; jump_en = 0; jump_addr = '0; hold_req = 0;
        rs1 = '0; rs2 = '0; ex_is_load = 0; ex_wd = '0;
    endtask

    // One clock: predict, compare mid-cycle, advance the model at the edge
    task automatic step(input string tag);
        logic        e_je, e_hp, e_hi, e_fi, e_fe, redirect, stall, lu;
        logic [31:0] e_ja;
        logic [1:0]  e_st;
        logic [39:0] obs, exp_v;
        int          nfl;
        bit          nh, npv;
        logic [31:0] npa;

        e_je = 0; e_ja = '0; e_hp = 0; e_hi = 0; e_fi = 0; e_fe = 0;
        redirect = 0; stall = 0;
        nfl = m_flush_left; nh = m_holding; npv = m_pend_v; npa = m_pend_a;
        lu = ex_is_load && (ex_wd != 0) && (ex_wd == rs1 || ex_wd == rs2);
        e_st = (m_flush_left > 0) ? 2'd1 : (m_holding ? 2'd2 : 2'd0);

        if (rst) begin
            e_st = 2'd0; nfl = 0; nh = 0; npv = 0;
        end else if (m_flush_left > 0) begin
            e_fi = 1; e_fe = 1;
            if (jump_en) begin redirect = 1; e_ja = jump_addr; end
            else nfl = m_flush_left - 1;
        end else if (m_holding) begin
            if (hold_req) begin
                stall = 1;
                if (jump_en) begin npv = 1; npa = jump_addr; end
            end else begin
                nh = 0;
                if (jump_en)       begin redirect = 1; e_ja = jump_addr; end
                else if (m_pend_v) begin redirect = 1; e_ja = m_pend_a; end
                else if (lu)       stall = 1;
            end
        end else begin
            if (jump_en)       begin redirect = 1; e_ja = jump_addr; end
            else if (hold_req) begin stall = 1; nh = 1; end
            else if (lu)       stall = 1;
        end

        if (redirect) begin
            e_je = 1; e_fi = 1; e_fe = 1; nfl = FC - 1; npv = 0; nh = 0;
        end
        if (stall) begin
            e_hp = 1; e_hi = 1; e_fe = 1;
        end

        #2;
        obs   = {state, jump_en_out, jump_addr_out, hold_pc, hold_if_id, flush_if_id, flush_id_ex};
        exp_v = {e_st, e_je, e_ja, e_hp, e_hi, e_fi, e_fe};
        n_vectors++;
        assert (obs === exp_v) else begin
            n_miscompares++;
            $error("FAIL %s: observed %h expected %h (st,je,addr,hp,hi,fi,fe)", tag, obs, exp_v);
        end

        @(posedge clk);
        m_flush_left = nfl; m_holding = nh; m_pend_v = npv; m_pend_a = npa;
        if (rst) begin
            m_stall_cnt = 0; m_jump_cnt = 0;
        end else begin
            if (e_hp) m_stall_cnt++;
            if (e_je) m_jump_cnt++;
        end
        #1;
    endtask

    initial begin
        idle();
        @(posedge clk); #1;

        // Reset, then reset again in the middle of a hold
        rst = 1; step("rst_init");
        idle(); hold_req = 1; step("hold_enter");
        step("hold_stay");
        rst = 1; step("rst_in_hold_0");
        step("rst_in_hold_1");
        idle(); step("after_rst_run");

        // Single redirect to 0x40
        step("idle_0"); step("idle_1");
        jump_en = 1; jump_addr = 32'h0000_0040; step("jump_40");
        idle(); step("flush_tail"); step("flush_done"); step("idle_2");

        // Load-use on rs2, then a load into x0
        ex_is_load = 1; ex_wd = 5'd5; rs2 = 5'd5; step("load_use_rs2");
        idle(); step("load_use_clear");
        ex_is_load = 1; ex_wd = 5'd0; rs2 = 5'd0; step("load_x0_no_stall");
        idle(); ex_is_load = 1; ex_wd = 5'd7; rs1 = 5'd7; step("load_use_rs1");
        idle(); step("idle_3");

        // Hold with two jumps parked, newest wins on release
        hold_req = 1; step("hold_c10");
        jump_en = 1; jump_addr = 32'h100; step("hold_c11_jmp100");
        jump_addr = 32'h200; step("hold_c12_jmp200");
        jump_en = 0; jump_addr = '0; step("hold_c13");
        step("hold_c14");
        idle(); step("release_c15"); step("flush_c16"); step("run_c17");

        // Jump and hold together in RUN
        jump_en = 1; jump_addr = 32'h300; hold_req = 1; step("jump_beats_hold");
        idle(); step("idle_4"); step("idle_5");

        // Jump in the second flush cycle extends the flush window
        jump_en = 1; jump_addr = 32'h400; step("jump_a");
        jump_addr = 32'h500; step("jump_in_flush");
        idle(); step("flush_ext"); step("flush_end");

        // Release with a fresh jump overriding the parked one
        hold_req = 1; step("hold2_0");
        jump_en = 1; jump_addr = 32'h600; step("hold2_park");
        hold_req = 0; jump_addr = 32'h700; step("release_fresh_jump");
        idle(); step("idle_6"); step("idle_7");

        // Release with no parked jump but a load-use hazard
        hold_req = 1; step("hold3_0");
        hold_req = 0; ex_is_load = 1; ex_wd = 5'd3; rs1 = 5'd3; step("release_load_use");
        idle(); step("idle_8");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            jump_en    = ($urandom_range(0, 7) == 0);
            jump_addr  = $urandom;
            hold_req   = hold_req ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 6) == 0);
            ex_is_load = $urandom_range(0, 1);
            ex_wd      = 5'($urandom_range(0, 3));
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            step("random");
        end
        idle(); step("final_idle");

`ifdef PIPE_CTRL_PERF_EN
        n_vectors++;
        assert (perf_stall_cnt === 32'(m_stall_cnt)) else begin
            n_miscompares++;
            $error("FAIL perf_stall: observed %0d expected %0d", perf_stall_cnt, m_stall_cnt);
        end
        n_vectors++;
        assert (perf_flush_cnt === 32'(m_jump_cnt)) else begin
            n_miscompares++;
            $error("FAIL perf_flush: observed %0d expected %0d", perf_flush_cnt, m_jump_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
